huffman_stream_decoder: RTL and testbench

- Receiving end of the Huffman coding path: takes the six code/mask pairs produced by the encoder table (HC1..HC6, M1..M6) and decodes a serial, MSB-first bitstream back into symbol indices 1..6.
- Sits downstream of the code-table memory. Loads the table on a load strobe, then accepts one bit per valid cycle and emits one symbol per completed codeword.
- Flags codewords that cannot be resolved within 8 bits.

---
 rtl/huffman_stream_decoder_if.sv | 36 +++
 rtl/huffman_stream_decoder.sv | 178 +++++++++++++++++
 tb/tb_huffman_stream_decoder.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/huffman_stream_decoder_if.sv
// ---------------------------------------------------------------------------
// huffman_stream_decoder_if
//   Bundles the code table, serial bit handshake and symbol outputs of the
//   Huffman stream decoder.
//   master : drives load/HC1..HC6/M1..M6/flush/bit_in/bit_valid,
//            observes bit_ready/sym_valid/sym/err/sym_cnt
//   slave  : the decoder itself (mirror directions)
// ---------------------------------------------------------------------------
interface huffman_stream_decoder_if #(
  parameter int CW    = 8,
  parameter int CNT_W = 16
);
  logic             load;
  logic [CW-1:0]    HC1, HC2, HC3, HC4, HC5, HC6;
  logic [CW-1:0]    M1, M2, M3, M4, M5, M6;
  logic             flush;
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic             sym_valid;
  logic [2:0]       sym;
  logic             err;
  logic [CNT_W-1:0] sym_cnt;

  modport master (
    output load, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
    output flush, bit_in, bit_valid,
    input  bit_ready, sym_valid, sym, err, sym_cnt
  );

  modport slave (
    input  load, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
    input  flush, bit_in, bit_valid,
    output bit_ready, sym_valid, sym, err, sym_cnt
  );
endinterface

// File: rtl/huffman_stream_decoder.sv
// ---------------------------------------------------------------------------
// huffman_stream_decoder
//   Decodes a serial MSB-first Huffman bitstream into symbol indices 1..6
//   using a six-entry code/mask table captured on load.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : huffman_stream_decoder_if.slave
//            load/HC1..HC6/M1..M6  table capture (aborts partial codeword)
//            flush                 drop partial codeword, leave error state
//            bit_in/bit_valid/bit_ready  serial bit handshake
//            sym_valid/sym         one-cycle symbol pulse, sym held after
//            err                   sticky "no codeword within CW bits"
//            sym_cnt               symbols decoded since reset/load (wraps)
// ---------------------------------------------------------------------------
module huffman_stream_decoder #(
  parameter int CW    = 8,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  huffman_stream_decoder_if.slave bus
);

  localparam int NSYM = 6;
  // Length counter must be able to represent CW itself.
  localparam int LW   = $clog2(CW + 1);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ERR} state_t;

  function automatic logic [LW-1:0] popcount(input logic [CW-1:0] v);
    logic [LW-1:0] c;
    c = '0;
    for (int k = 0; k < CW; k++) begin
      c = c + LW'(v[k]);
    end
    return c;
  endfunction

  // Table inputs gathered into arrays so the per-symbol logic can be generated.
  logic [CW-1:0] hc_in [NSYM];
  logic [CW-1:0] m_in  [NSYM];

  assign hc_in[0] = bus.HC1;  assign m_in[0] = bus.M1;
  assign hc_in[1] = bus.HC2;  assign m_in[1] = bus.M2;
  assign hc_in[2] = bus.HC3;  assign m_in[2] = bus.M3;
  assign hc_in[3] = bus.HC4;  assign m_in[3] = bus.M4;
  assign hc_in[4] = bus.HC5;  assign m_in[4] = bus.M5;
  assign hc_in[5] = bus.HC6;  assign m_in[5] = bus.M6;

  logic [CW-1:0]    hc_q [NSYM];
  logic [CW-1:0]    m_q  [NSYM];

  state_t           state_q, state_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [LW-1:0]    len_q, len_d;
  logic             sym_valid_q, sym_valid_d;
  logic [2:0]       sym_q, sym_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Candidate accumulator/length as if the current bit were accepted.
  logic [CW-1:0]    acc_n;
  logic [LW-1:0]    len_n;
  logic [NSYM-1:0]  match;
  logic [2:0]       hit_sym;

  assign acc_n = {acc_q[CW-2:0], bus.bit_in};
  assign len_n = len_q + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NSYM; gi++) begin : g_sym
      always_ff @(posedge clk) begin
        if (reset) begin
          hc_q[gi] <= '0;
          m_q[gi]  <= '0;
        end else if (bus.load) begin
          hc_q[gi] <= hc_in[gi];
          m_q[gi]  <= m_in[gi];
        end
      end

      // Length equality stops a short code from matching inside a longer
      // prefix that merely shares its low-order bits.
      assign match[gi] = (m_q[gi] != '0) &&
                         ((acc_n & m_q[gi]) == hc_q[gi]) &&
                         (popcount(m_q[gi]) == len_n);
    end
  endgenerate

  // Scan downward so the lowest matching index is the last assignment.
  always_comb begin
    hit_sym = '0;
    for (int i = NSYM - 1; i >= 0; i--) begin
      if (match[i]) hit_sym = 3'(i + 1);
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    len_d       = len_q;
    sym_valid_d = 1'b0;
    sym_d       = sym_q;
    err_d       = err_q;
    cnt_d       = cnt_q;

    if (bus.load) begin
      state_d = S_DECODE;
      acc_d   = '0;
      len_d   = '0;
      err_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
        end
        S_DECODE: begin
          if (bus.flush) begin
            acc_d = '0;
            len_d = '0;
          end else if (bus.bit_valid) begin
            if (hit_sym != '0) begin
              // Clearing here lets the next codeword start on the very next cycle.
              sym_valid_d = 1'b1;
              sym_d       = hit_sym;
              cnt_d       = cnt_q + 1'b1;
              acc_d       = '0;
              len_d       = '0;
            end else if (len_n == LW'(CW)) begin
              state_d = S_ERR;
              err_d   = 1'b1;
              acc_d   = '0;
              len_d   = '0;
            end else begin
              acc_d = acc_n;
              len_d = len_n;
            end
          end
        end
        S_ERR: begin
          if (bus.flush) begin
            state_d = S_DECODE;
            err_d   = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      len_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      sym_valid_q <= sym_valid_d;
      sym_q       <= sym_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.bit_ready = (state_q == S_DECODE);
  assign bus.sym_valid = sym_valid_q;
  assign bus.sym       = sym_q;
  assign bus.err       = err_q;
  assign bus.sym_cnt   = cnt_q;

endmodule

// File: tb/tb_huffman_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_huffman_stream_decoder
//   Drives the decoder with directed vectors, hand-written corner sequences
//   and random traffic. A bit-queue model of the code table predicts every
//   output each cycle.
// ---------------------------------------------------------------------------
module tb_huffman_stream_decoder;

  localparam int CW    = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  huffman_stream_decoder_if #(.CW(CW), .CNT_W(CNT_W)) bus ();

  huffman_stream_decoder #(.CW(CW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [CW-1:0] t_hc [6];
  logic [CW-1:0] t_m  [6];

  assign bus.HC1 = t_hc[0];  assign bus.M1 = t_m[0];
  assign bus.HC2 = t_hc[1];  assign bus.M2 = t_m[1];
  assign bus.HC3 = t_hc[2];  assign bus.M3 = t_m[2];
  assign bus.HC4 = t_hc[3];  assign bus.M4 = t_m[3];
  assign bus.HC5 = t_hc[4];  assign bus.M5 = t_m[4];
  assign bus.HC6 = t_hc[5];  assign bus.M6 = t_m[5];

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: received prefix as a bit queue, oldest first.
  bit            m_loaded, m_err, m_sv;
  int            m_sym, m_cnt;
  bit            m_pre [$];
  logic [CW-1:0] m_hc [6];
  logic [CW-1:0] m_m  [6];

  typedef struct {
    bit bi;
    bit exp_sv;
    int exp_sym;
    int exp_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Symbol i's codeword is the low popcount(M) bits of HC, sent MSB first.
  function automatic bit code_matches(int i);
    int L;
    if (m_m[i] == '0) return 1'b0;
    L = $countones(m_m[i]);
    if (L != m_pre.size()) return 1'b0;
    for (int k = 0; k < L; k++) begin
      if (m_pre[k] != m_hc[i][L-1-k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input bit rst, ld, fl, bv, bi);
    int hit;
    m_sv = 1'b0;
    if (rst) begin
      m_loaded = 1'b0; m_err = 1'b0; m_sym = 0; m_cnt = 0;
      m_pre.delete();
    end else if (ld) begin
      for (int i = 0; i < 6; i++) begin m_hc[i] = t_hc[i]; m_m[i] = t_m[i]; end
      m_pre.delete(); m_err = 1'b0; m_cnt = 0; m_loaded = 1'b1;
    end else if (!m_loaded) begin
      // no table yet: everything ignored
    end else if (m_err) begin
      if (fl) m_err = 1'b0;
    end else if (fl) begin
      m_pre.delete();
    end else if (bv) begin
      m_pre.push_back(bi);
      hit = 0;
      for (int i = 0; i < 6; i++) if (hit == 0 && code_matches(i)) hit = i + 1;
      if (hit != 0) begin
        m_sv = 1'b1; m_sym = hit; m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_pre.delete();
      end else if (m_pre.size() == CW) begin
        m_err = 1'b1;
        m_pre.delete();
      end
    end
  endtask

  task automatic cyc(input bit rst, ld, fl, bv, bi);
    reset = rst; bus.load = ld; bus.flush = fl; bus.bit_valid = bv; bus.bit_in = bi;
    model_step(rst, ld, fl, bv, bi);
    @(posedge clk);
    #1;
    chk("model sym_valid", 32'(bus.sym_valid), 32'(m_sv));
    chk("model sym",       32'(bus.sym),       32'(m_sym));
    chk("model err",       32'(bus.err),       32'(m_err));
    chk("model bit_ready", 32'(bus.bit_ready), 32'(m_loaded && !m_err));
    chk("model sym_cnt",   32'(bus.sym_cnt),   32'(m_cnt));
    reset = 1'b0; bus.load = 1'b0; bus.flush = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
  endtask

  task automatic bitc(input bit b);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic set_ref();
    t_hc[0] = 8'h00; t_m[0] = 8'h01;
    t_hc[1] = 8'h02; t_m[1] = 8'h03;
    t_hc[2] = 8'h06; t_m[2] = 8'h07;
    t_hc[3] = 8'h0E; t_m[3] = 8'h0F;
    t_hc[4] = 8'h1E; t_m[4] = 8'h1F;
    t_hc[5] = 8'h1F; t_m[5] = 8'h1F;
  endtask

  vec_t vecs [15];

  initial begin
    // Stream 0,110,11111,1110,10 with bit_valid held high.
    vecs[0]  = '{1'b0, 1'b1, 1, 1};
    vecs[1]  = '{1'b1, 1'b0, 1, 1};
    vecs[2]  = '{1'b1, 1'b0, 1, 1};
    vecs[3]  = '{1'b0, 1'b1, 3, 2};
    vecs[4]  = '{1'b1, 1'b0, 3, 2};
    vecs[5]  = '{1'b1, 1'b0, 3, 2};
    vecs[6]  = '{1'b1, 1'b0, 3, 2};
    vecs[7]  = '{1'b1, 1'b0, 3, 2};
    vecs[8]  = '{1'b1, 1'b1, 6, 3};
    vecs[9]  = '{1'b1, 1'b0, 6, 3};
    vecs[10] = '{1'b1, 1'b0, 6, 3};
    vecs[11] = '{1'b1, 1'b0, 6, 3};
    vecs[12] = '{1'b0, 1'b1, 4, 4};
    vecs[13] = '{1'b1, 1'b0, 4, 4};
    vecs[14] = '{1'b0, 1'b1, 2, 5};

    set_ref();
    m_loaded = 1'b0; m_err = 1'b0; m_sv = 1'b0; m_sym = 0; m_cnt = 0;

    // Reset state.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset bit_ready", 32'(bus.bit_ready), 32'd0);
    chk("reset sym_cnt",   32'(bus.sym_cnt),   32'd0);
    bitc(1'b1);
    chk("idle ignores bit", 32'(bus.sym_valid), 32'd0);

    // Load, then "10" -> symbol 2.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("load bit_ready", 32'(bus.bit_ready), 32'd1);
    bitc(1'b1);
    chk("A mid sym_valid", 32'(bus.sym_valid), 32'd0);
    chk("A mid bit_ready", 32'(bus.bit_ready), 32'd1);
    bitc(1'b0);
    chk("A sym_valid", 32'(bus.sym_valid), 32'd1);
    chk("A sym",       32'(bus.sym),       32'd2);
    chk("A sym_cnt",   32'(bus.sym_cnt),   32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("A pulse one cycle", 32'(bus.sym_valid), 32'd0);

    // Back-to-back stream from the vector table.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    foreach (vecs[i]) begin
      bitc(vecs[i].bi);
      chk("vec sym_valid", 32'(bus.sym_valid), 32'(vecs[i].exp_sv));
      if (vecs[i].exp_sv) chk("vec sym", 32'(bus.sym), 32'(vecs[i].exp_sym));
      chk("vec sym_cnt",   32'(bus.sym_cnt),   32'(vecs[i].exp_cnt));
      chk("vec err",       32'(bus.err),       32'd0);
    end

    // Overflow: M6 unused, eight 1s never resolve.
    t_m[5] = 8'h00;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) bitc(1'b1);
    chk("B err before 8th", 32'(bus.err), 32'd0);
    bitc(1'b1);
    chk("B err",       32'(bus.err),       32'd1);
    chk("B bit_ready", 32'(bus.bit_ready), 32'd0);
    chk("B sym_valid", 32'(bus.sym_valid), 32'd0);
    bitc(1'b0);
    bitc(1'b0);
    chk("B ignored cnt", 32'(bus.sym_cnt), 32'd0);
    chk("B err sticky",  32'(bus.err),     32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("B flush err",       32'(bus.err),       32'd0);
    chk("B flush bit_ready", 32'(bus.bit_ready), 32'd1);
    bitc(1'b0);
    chk("B sym", 32'(bus.sym), 32'd1);
    chk("B sym_valid", 32'(bus.sym_valid), 32'd1);

    // Flush mid-codeword; the bit offered with flush is dropped.
    bitc(1'b1); bitc(1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("C flush no sym", 32'(bus.sym_valid), 32'd0);
    bitc(1'b0);
    chk("C sym",     32'(bus.sym),     32'd1);
    chk("C sym_cnt", 32'(bus.sym_cnt), 32'd2);
    // Same with load (reference table restored).
    bitc(1'b1); bitc(1'b1);
    set_ref();
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("C load no sym", 32'(bus.sym_valid), 32'd0);
    chk("C load cnt",    32'(bus.sym_cnt),   32'd0);
    bitc(1'b0);
    chk("C load sym",     32'(bus.sym),     32'd1);
    chk("C load sym_cnt", 32'(bus.sym_cnt), 32'd1);

    // Reset mid-codeword.
    bitc(1'b1); bitc(1'b1); bitc(1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("D sym",       32'(bus.sym),       32'd0);
    chk("D bit_ready", 32'(bus.bit_ready), 32'd0);
    chk("D sym_cnt",   32'(bus.sym_cnt),   32'd0);
    bitc(1'b1); bitc(1'b0);
    chk("D ignored", 32'(bus.sym_valid), 32'd0);

    // Gapped bit_valid: 1,_,1,_,0 -> single symbol 3.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bitc(1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    bitc(1'b1);
    chk("E mid", 32'(bus.sym_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bitc(1'b0);
    chk("E sym_valid", 32'(bus.sym_valid), 32'd1);
    chk("E sym",       32'(bus.sym),       32'd3);
    chk("E sym_cnt",   32'(bus.sym_cnt),   32'd1);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int r;
      bit rst, ld, fl;
      r   = $urandom_range(0, 999);
      rst = (r < 3);
      ld  = (r >= 3 && r < 15);
      fl  = (r >= 15 && r < 45);
      if (ld) begin
        if ($urandom_range(0, 1) == 0) set_ref();
        else begin
          for (int i = 0; i < 6; i++) begin
            int L;
            L = $urandom_range(0, CW);
            t_m[i]  = CW'((1 << L) - 1);
            t_hc[i] = CW'($urandom) & t_m[i];
          end
        end
      end
      cyc(rst, ld, fl, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
